// File: rtl/pipe_phy_ctrl_responder.sv
// pipe_phy_ctrl_responder: PHY-side PIPE responder for PowerDown, Rate and receiver-detect handshakes
module pipe_phy_ctrl_responder #(
   parameter int RESET_CYCLES   = 16,
   parameter int PD_LATENCY     = 8,
   parameter int RATE_LATENCY   = 32,
   parameter int DETECT_LATENCY = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] power_down,
   input  logic [3:0] rate,
   input  logic       tx_detect_rx,
   input  logic [3:0] tx_elec_idle,
   input  logic       rx_present,
   output logic       phy_status,
   output logic [2:0] rx_status,
   output logic [3:0] cur_power_down,
   output logic [3:0] cur_rate,
   output logic       busy,
   output logic       illegal_cmd
);
   localparam logic [2:0] RST_HOLD    = 3'd0;
   localparam logic [2:0] IDLE        = 3'd1;
   localparam logic [2:0] PD_WAIT     = 3'd2;
   localparam logic [2:0] RATE_WAIT   = 3'd3;
   localparam logic [2:0] DET_WAIT    = 3'd4;
   localparam logic [2:0] STATUS      = 3'd5;
   localparam logic [2:0] DET_RELEASE = 3'd6;
   localparam logic [3:0] P1          = 4'd2;
   localparam logic [7:0] RST_END  = 8'(RESET_CYCLES - 1);
   localparam logic [7:0] PD_END   = 8'(PD_LATENCY - 1);
   localparam logic [7:0] RATE_END = 8'(RATE_LATENCY - 1);
   localparam logic [7:0] DET_END  = 8'(DETECT_LATENCY - 1);

   if (RESET_CYCLES < 1 || RESET_CYCLES > 255 || PD_LATENCY < 1 || PD_LATENCY > 255 ||
       RATE_LATENCY < 1 || RATE_LATENCY > 255 || DETECT_LATENCY < 1 || DETECT_LATENCY > 255) begin : g_bad_param
      $error("pipe_phy_ctrl_responder: cycle parameters must lie in 1..255");
   end

   logic [2:0] state;
   logic [7:0] cnt;
   logic [3:0] tgt;
   logic [3:0] pd_prev;
   logic       det_op;
   logic       ill_done;
   logic       det_ill_done;
   logic       pd_legal;

   assign pd_legal   = ~|power_down[3:2];
   assign phy_status = (state == RST_HOLD) || (state == STATUS);
   assign busy       = state != IDLE;
   assign rx_status  = (state == STATUS && det_op && rx_present) ? 3'b011 : 3'b000;

   // Handshake FSM: accept one request from IDLE, time it out, pulse PhyStatus, apply the captured target
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= RST_HOLD;
         cnt            <= '0;
         tgt            <= '0;
         det_op         <= 1'b0;
         cur_power_down <= P1;
         cur_rate       <= '0;
         illegal_cmd    <= 1'b0;
         ill_done       <= 1'b0;
         det_ill_done   <= 1'b0;
         pd_prev        <= '0;
      end else begin
         illegal_cmd <= 1'b0;
         pd_prev     <= power_down;
         cnt         <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
         if (power_down != pd_prev) ill_done <= 1'b0;
         if (!tx_detect_rx) det_ill_done <= 1'b0;
         case (state)
            RST_HOLD: if (cnt == RST_END) state <= IDLE;
            IDLE: begin
               cnt <= '0;
               if (rate != cur_rate) begin
                  state  <= RATE_WAIT;
                  tgt    <= rate;
                  det_op <= 1'b0;
               end else if (pd_legal && power_down != cur_power_down) begin
                  state  <= PD_WAIT;
                  tgt    <= power_down;
                  det_op <= 1'b0;
               end else if (!pd_legal) begin
                  illegal_cmd <= !ill_done || power_down != pd_prev;
                  ill_done    <= 1'b1;
               end else if (tx_detect_rx) begin
                  if (cur_power_down == P1 && tx_elec_idle[0]) begin
                     state  <= DET_WAIT;
                     det_op <= 1'b1;
                  end else begin
                     illegal_cmd  <= !det_ill_done;
                     det_ill_done <= 1'b1;
                  end
               end
            end
            PD_WAIT: if (cnt == PD_END) begin
               state          <= STATUS;
               cur_power_down <= tgt;
            end
            RATE_WAIT: if (cnt == RATE_END) begin
               state    <= STATUS;
               cur_rate <= tgt;
            end
            DET_WAIT:    if (cnt == DET_END) state <= STATUS;
            STATUS:      state <= det_op ? DET_RELEASE : IDLE;
            DET_RELEASE: if (!tx_detect_rx) state <= IDLE;
            default:     state <= IDLE;
         endcase
      end
   end
endmodule
